regfile_bp: RTL and testbench

Parametrised successor to the core's integer register file: NREG × XLEN storage with two combinational read ports, one synchronous write port, optional hardwired-zero register 0, and write-to-read bypass. It adds a sequential post-reset clear sequencer and a per-register pending (scoreboard) bit, so decode can detect long-latency hazards. It sits between decode (read/mark) and writeback (write).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_if.sv | 38 +++
 rtl/regfile_sb.sv | 42 ++++
 rtl/regfile_bp.sv | 104 ++++++++++
 tb/tb_regfile_bp.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the integer register file and its clients.
package regfile_pkg;

   // Post-reset clear sequencer states.
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Default data width and register count used by decode and writeback.
   localparam int DEF_XLEN = 32;
   localparam int DEF_NREG = 32;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file.
//
// Handshake: there is no valid/ready pairing per transfer. ready is a level;
// while it is 1 every write (we) and mark (mark_en) presented at a rising
// edge is accepted on that edge, with no backpressure. While ready is 0 the
// file is clearing itself, ignores we/mark_en and returns 0 on all reads.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int NREG = DEF_NREG
);
   localparam int AW = $clog2(NREG);

   logic            we;
   logic [AW-1:0]   wa;
   logic [XLEN-1:0] wd;
   logic [AW-1:0]   ra1;
   logic [AW-1:0]   ra2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            mark_en;
   logic [AW-1:0]   mark_addr;
   logic            busy1;
   logic            busy2;
   logic            ready;

   modport master (
      output we, wa, wd, ra1, ra2, mark_en, mark_addr,
      input  rd1, rd2, busy1, busy2, ready
   );

   modport slave (
      input  we, wa, wd, ra1, ra2, mark_en, mark_addr,
      output rd1, rd2, busy1, busy2, ready
   );

endinterface

// File: rtl/regfile_sb.sv
// Pending-bit scoreboard: one bit per register, set by mark, cleared by write.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int NREG     = DEF_NREG,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_mark,
   input  logic [AW-1:0] i_mark_addr,
   input  logic          i_clr,
   input  logic [AW-1:0] i_clr_addr,
   input  logic [AW-1:0] i_ra1,
   input  logic [AW-1:0] i_ra2,
   output logic          o_busy1,
   output logic          o_busy2
);

   logic [NREG-1:0] r_pend;

   // Pending bits: clear on write, then set on mark so a same-edge mark wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pend <= '0;
      end else begin
         if (i_clr)  r_pend[i_clr_addr]  <= 1'b0;
         if (i_mark) r_pend[i_mark_addr] <= 1'b1;
      end
   end

   // Busy lookup with same-cycle write forwarding and hardwired-zero masking.
   always_comb begin
      o_busy1 = r_pend[i_ra1] & ~(BYPASS & i_clr & (i_clr_addr == i_ra1));
      o_busy2 = r_pend[i_ra2] & ~(BYPASS & i_clr & (i_clr_addr == i_ra2));
      if (ZERO_REG && (i_ra1 == '0)) o_busy1 = 1'b0;
      if (ZERO_REG && (i_ra2 == '0)) o_busy2 = 1'b0;
   end

endmodule

// File: rtl/regfile_bp.sv
// Integer register file with post-reset clear sequencer, write-to-read
// bypass, optional hardwired zero register and a pending-bit scoreboard.
module regfile_bp
   import regfile_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int NREG     = DEF_NREG,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic     clk,
   input  logic     rst,
   regfile_if.slave bus,
   output state_t   o_state
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_ctr;
   logic [AW-1:0]   w_ctr_nxt;
   logic [XLEN-1:0] r_x [NREG];

   logic            w_run;
   logic            w_user_we;
   logic            w_mark;
   logic            w_wen;
   logic [AW-1:0]   w_waddr;
   logic [XLEN-1:0] w_wdata;
   logic            w_busy1;
   logic            w_busy2;

   // Clear sequencer state and counter; reset restarts the sweep at 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= CLEAR;
         r_ctr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ctr   <= w_ctr_nxt;
      end
   end

   // Next state: sweep every address once, leave CLEAR after the last one.
   always_comb begin
      w_state_nxt = r_state;
      w_ctr_nxt   = r_ctr;
      if (r_state == CLEAR) begin
         w_ctr_nxt = r_ctr + AW'(1);
         if (r_ctr == AW'(NREG - 1)) w_state_nxt = RUN;
      end
   end

   // Write-port steering: clear sweep owns the port until RUN.
   always_comb begin
      w_run     = (r_state == RUN);
      w_user_we = w_run & bus.we & ~(ZERO_REG & (bus.wa == '0));
      w_mark    = w_run & bus.mark_en & ~(ZERO_REG & (bus.mark_addr == '0));
      w_wen     = rst & (~w_run | w_user_we);
      w_waddr   = w_run ? bus.wa : r_ctr;
      w_wdata   = w_run ? bus.wd : '0;
   end

   // Register storage; initial contents are defined by the clear sweep.
   always_ff @(posedge clk) begin
      if (w_wen) r_x[w_waddr] <= w_wdata;
   end

   // Read muxes: storage, then bypass, then zero/not-ready override.
   always_comb begin
      bus.rd1 = r_x[bus.ra1];
      bus.rd2 = r_x[bus.ra2];
      if (BYPASS && w_user_we && (bus.wa == bus.ra1)) bus.rd1 = bus.wd;
      if (BYPASS && w_user_we && (bus.wa == bus.ra2)) bus.rd2 = bus.wd;
      if (!w_run || (ZERO_REG && (bus.ra1 == '0))) bus.rd1 = '0;
      if (!w_run || (ZERO_REG && (bus.ra2 == '0))) bus.rd2 = '0;
   end

   regfile_sb #(
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_mark      (w_mark),
      .i_mark_addr (bus.mark_addr),
      .i_clr       (w_user_we),
      .i_clr_addr  (bus.wa),
      .i_ra1       (bus.ra1),
      .i_ra2       (bus.ra2),
      .o_busy1     (w_busy1),
      .o_busy2     (w_busy2)
   );

   // Status outputs; busy is forced low while the sweep runs.
   always_comb begin
      bus.busy1 = w_busy1 & w_run;
      bus.busy2 = w_busy2 & w_run;
      bus.ready = w_run;
      o_state   = r_state;
   end

endmodule

// File: tb/tb_regfile_bp.sv
// Bench for regfile_bp: a bypassing and a non-bypassing instance driven in
// parallel, checked against a behavioural model of the register file.
module tb_regfile_bp;
   import regfile_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   regfile_if #(.XLEN(32), .NREG(32)) bus ();
   regfile_if #(.XLEN(32), .NREG(32)) bus_nb ();
   state_t st;
   state_t st_nb;

   logic        t_we;
   logic [4:0]  t_wa;
   logic [31:0] t_wd;
   logic [4:0]  t_ra1;
   logic [4:0]  t_ra2;
   logic        t_mark;
   logic [4:0]  t_maddr;

   assign bus.we = t_we;       assign bus_nb.we = t_we;
   assign bus.wa = t_wa;       assign bus_nb.wa = t_wa;
   assign bus.wd = t_wd;       assign bus_nb.wd = t_wd;
   assign bus.ra1 = t_ra1;     assign bus_nb.ra1 = t_ra1;
   assign bus.ra2 = t_ra2;     assign bus_nb.ra2 = t_ra2;
   assign bus.mark_en = t_mark;     assign bus_nb.mark_en = t_mark;
   assign bus.mark_addr = t_maddr;  assign bus_nb.mark_addr = t_maddr;

   regfile_bp #(.XLEN(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk (clk), .rst (rst), .bus (bus), .o_state (st)
   );
   regfile_bp #(.XLEN(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk (clk), .rst (rst), .bus (bus_nb), .o_state (st_nb)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   int          m_clr_cnt;
   bit          m_ready;
   int          n_checks;
   int          n_errors;

   // Advance one clock edge and apply the register-file rules to the model.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         m_clr_cnt = 0;
         m_ready   = 1'b0;
         for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (!m_ready) begin
         m_mem[m_clr_cnt] = 32'h0;
         m_clr_cnt++;
         if (m_clr_cnt == 32) m_ready = 1'b1;
      end else begin
         if (t_we && t_wa != 5'd0) begin
            m_mem[t_wa]  = t_wd;
            m_pend[t_wa] = 1'b0;
         end
         if (t_mark && t_maddr != 5'd0) m_pend[t_maddr] = 1'b1;
      end
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
      if (!m_ready || ra == 5'd0) return 32'h0;
      if (byp && t_we && t_wa == ra) return t_wd;
      return m_mem[ra];
   endfunction

   function automatic logic exp_busy(input logic [4:0] ra, input bit byp);
      if (!m_ready || ra == 5'd0) return 1'b0;
      if (byp && t_we && t_wa == ra) return 1'b0;
      return m_pend[ra];
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      int lat;
      rst = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.ready !== 1'b0 || bus_nb.ready !== 1'b0) begin
         n_errors++; $display("FAIL reset_ready got %b/%b want 0", bus.ready, bus_nb.ready);
      end
      n_checks++;
      if (bus.rd1 !== 32'h0 || bus.busy1 !== 1'b0 || st !== CLEAR) begin
         n_errors++; $display("FAIL reset_outputs rd1=%h busy1=%b state=%0d want 0/0/CLEAR", bus.rd1, bus.busy1, st);
      end
      rst = 1'b1;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (bus.ready === 1'b1) begin lat = c; break; end
      end
      n_checks++;
      if (lat != 32) begin
         n_errors++; $display("FAIL clear_latency got %0d want 32", lat);
      end
      n_checks++;
      if (st !== RUN || bus_nb.ready !== 1'b1) begin
         n_errors++; $display("FAIL run_state state=%0d nb_ready=%b want RUN/1", st, bus_nb.ready);
      end
      for (int a = 0; a < 32; a++) begin
         t_ra1 = 5'(a);
         t_ra2 = 5'(31 - a);
         #1;
         n_checks++;
         if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0 || bus_nb.rd1 !== 32'h0 || bus_nb.rd2 !== 32'h0) begin
            n_errors++; $display("FAIL cleared_read addr %0d got %h %h %h %h want 0", a, bus.rd1, bus.rd2, bus_nb.rd1, bus_nb.rd2);
         end
         tick();
      end
   endtask

   task automatic test_bypass();
      t_we = 1'b1; t_wa = 5'd5; t_wd = 32'hDEADBEEF; t_ra1 = 5'd5;
      #1;
      n_checks++;
      if (bus.rd1 !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL bypass_same_cycle got %h want deadbeef", bus.rd1);
      end
      n_checks++;
      if (bus_nb.rd1 !== 32'h0) begin
         n_errors++; $display("FAIL nobypass_old_value got %h want 0", bus_nb.rd1);
      end
      tick();
      t_we = 1'b0;
      #1;
      n_checks++;
      if (bus.rd1 !== 32'hDEADBEEF || bus_nb.rd1 !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL write_hold got %h/%h want deadbeef", bus.rd1, bus_nb.rd1);
      end
      tick();
   endtask

   task automatic test_zero();
      t_we = 1'b1; t_wa = 5'd0; t_wd = 32'h1234;
      #1;
      tick();
      t_we = 1'b0; t_ra1 = 5'd0; t_ra2 = 5'd0;
      #1;
      n_checks++;
      if (bus.rd1 !== 32'h0 || bus.rd2 !== 32'h0 || bus_nb.rd1 !== 32'h0 || bus_nb.rd2 !== 32'h0) begin
         n_errors++; $display("FAIL zero_read got %h %h %h %h want 0", bus.rd1, bus.rd2, bus_nb.rd1, bus_nb.rd2);
      end
      t_mark = 1'b1; t_maddr = 5'd0;
      tick();
      t_mark = 1'b0;
      #1;
      n_checks++;
      if (bus.busy1 !== 1'b0 || bus_nb.busy1 !== 1'b0) begin
         n_errors++; $display("FAIL zero_mark busy got %b/%b want 0", bus.busy1, bus_nb.busy1);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      t_mark = 1'b1; t_maddr = 5'd7; t_ra1 = 5'd7;
      #1;
      n_checks++;
      if (bus.busy1 !== 1'b0) begin
         n_errors++; $display("FAIL mark_not_early got %b want 0", bus.busy1);
      end
      tick();
      t_mark = 1'b0;
      #1;
      n_checks++;
      if (bus.busy1 !== 1'b1 || bus_nb.busy1 !== 1'b1) begin
         n_errors++; $display("FAIL mark_visible got %b/%b want 1", bus.busy1, bus_nb.busy1);
      end
      t_we = 1'b1; t_wa = 5'd7; t_wd = 32'h55;
      #1;
      n_checks++;
      if (bus.busy1 !== 1'b0 || bus.rd1 !== 32'h55) begin
         n_errors++; $display("FAIL write_clears_busy busy=%b rd=%h want 0/55", bus.busy1, bus.rd1);
      end
      n_checks++;
      if (bus_nb.busy1 !== 1'b1) begin
         n_errors++; $display("FAIL nobypass_busy_held got %b want 1", bus_nb.busy1);
      end
      tick();
      t_we = 1'b0;
      #1;
      n_checks++;
      if (bus_nb.busy1 !== 1'b0 || bus_nb.rd1 !== 32'h55) begin
         n_errors++; $display("FAIL nobypass_after_write busy=%b rd=%h want 0/55", bus_nb.busy1, bus_nb.rd1);
      end
      t_we = 1'b1; t_wa = 5'd9; t_wd = 32'h99AA; t_mark = 1'b1; t_maddr = 5'd9;
      tick();
      t_we = 1'b0; t_mark = 1'b0; t_ra2 = 5'd9;
      #1;
      n_checks++;
      if (bus.busy2 !== 1'b1 || bus_nb.busy2 !== 1'b1) begin
         n_errors++; $display("FAIL mark_wins busy got %b/%b want 1", bus.busy2, bus_nb.busy2);
      end
      n_checks++;
      if (bus.rd2 !== 32'h99AA || bus_nb.rd2 !== 32'h99AA) begin
         n_errors++; $display("FAIL mark_write_data got %h/%h want 99aa", bus.rd2, bus_nb.rd2);
      end
      tick();
   endtask

   task automatic test_random();
      int hi;
      for (int i = 0; i < 400; i++) begin
         hi = (i % 2 == 0) ? 7 : 31;
         t_we    = 1'($urandom_range(0, 1));
         t_wa    = 5'($urandom_range(0, hi));
         t_wd    = $urandom();
         t_mark  = 1'($urandom_range(0, 1));
         t_maddr = 5'($urandom_range(0, hi));
         t_ra1   = 5'($urandom_range(0, hi));
         t_ra2   = 5'($urandom_range(0, hi));
         #1;
         n_checks++;
         if (bus.rd1 !== exp_rd(t_ra1, 1'b1) || bus.rd2 !== exp_rd(t_ra2, 1'b1)) begin
            n_errors++; $display("FAIL rnd_rd_byp it %0d got %h %h want %h %h", i, bus.rd1, bus.rd2, exp_rd(t_ra1, 1'b1), exp_rd(t_ra2, 1'b1));
         end
         n_checks++;
         if (bus_nb.rd1 !== exp_rd(t_ra1, 1'b0) || bus_nb.rd2 !== exp_rd(t_ra2, 1'b0)) begin
            n_errors++; $display("FAIL rnd_rd_nobyp it %0d got %h %h want %h %h", i, bus_nb.rd1, bus_nb.rd2, exp_rd(t_ra1, 1'b0), exp_rd(t_ra2, 1'b0));
         end
         n_checks++;
         if (bus.busy1 !== exp_busy(t_ra1, 1'b1) || bus.busy2 !== exp_busy(t_ra2, 1'b1)) begin
            n_errors++; $display("FAIL rnd_busy_byp it %0d got %b %b want %b %b", i, bus.busy1, bus.busy2, exp_busy(t_ra1, 1'b1), exp_busy(t_ra2, 1'b1));
         end
         n_checks++;
         if (bus_nb.busy1 !== exp_busy(t_ra1, 1'b0) || bus_nb.busy2 !== exp_busy(t_ra2, 1'b0)) begin
            n_errors++; $display("FAIL rnd_busy_nobyp it %0d got %b %b want %b %b", i, bus_nb.busy1, bus_nb.busy2, exp_busy(t_ra1, 1'b0), exp_busy(t_ra2, 1'b0));
         end
         n_checks++;
         if (bus.ready !== m_ready || bus_nb.ready !== m_ready) begin
            n_errors++; $display("FAIL rnd_ready it %0d got %b/%b want %b", i, bus.ready, bus_nb.ready, m_ready);
         end
         tick();
      end
      t_we = 1'b0; t_mark = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      t_we = 1'b1; t_wa = 5'd3; t_wd = 32'hA5; t_mark = 1'b1; t_maddr = 5'd4;
      tick();
      t_we = 1'b0; t_mark = 1'b0; t_ra1 = 5'd3; t_ra2 = 5'd4;
      #1;
      n_checks++;
      if (bus.rd1 !== 32'hA5 || bus.busy2 !== 1'b1) begin
         n_errors++; $display("FAIL pre_reset rd1=%h busy2=%b want a5/1", bus.rd1, bus.busy2);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (10) tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.ready !== 1'b0 || st !== CLEAR || st_nb !== CLEAR) begin
         n_errors++; $display("FAIL mid_clear_reset ready=%b state=%0d/%0d want 0/CLEAR", bus.ready, st, st_nb);
      end
      rst = 1'b1;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 5) begin
            n_checks++;
            if (bus.rd1 !== 32'h0 || bus.busy2 !== 1'b0) begin
               n_errors++; $display("FAIL during_clear rd1=%h busy2=%b want 0/0", bus.rd1, bus.busy2);
            end
         end
         if (bus.ready === 1'b1) begin lat = c; break; end
      end
      n_checks++;
      if (lat != 32) begin
         n_errors++; $display("FAIL restart_latency got %0d want 32", lat);
      end
      n_checks++;
      if (bus.rd1 !== 32'h0 || bus_nb.rd1 !== 32'h0 || bus.busy2 !== 1'b0 || bus_nb.busy2 !== 1'b0) begin
         n_errors++; $display("FAIL after_restart rd1=%h/%h busy2=%b/%b want 0", bus.rd1, bus_nb.rd1, bus.busy2, bus_nb.busy2);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0; n_errors = 0;
      m_clr_cnt = 0; m_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin m_mem[i] = 32'h0; m_pend[i] = 1'b0; end
      rst = 1'b0;
      t_we = 1'b0; t_wa = '0; t_wd = '0; t_ra1 = '0; t_ra2 = '0; t_mark = 1'b0; t_maddr = '0;
      test_reset();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
